reg_file_dbg_access: RTL and testbench

- Debug/scan initiator for the 32x32 GPR register file; the requester side of the register file's write/read port interface.
- Accepts read, write and dump commands over a valid/ready channel and requests a core halt.
- Once the core acknowledges the halt, drives the register file's wr_en/wr_reg/wr_data/rd_reg ports directly, then returns results over a valid/ready response channel.
- Sits between the debug transport and the register file write/read-port muxes.

---
 rtl/reg_file_dbg_access_if.sv | 44 ++++
 rtl/reg_file_dbg_access.sv | 147 ++++++++++++++
 tb/tb_reg_file_dbg_access.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_dbg_access_if.sv
// rtl/reg_file_dbg_access_if.sv - command/response, halt and register-file port bundle
//
// Purpose: groups every non-clock signal of reg_file_dbg_access.
//   master modport : the debug access block (accepts commands, drives the RF ports)
//   slave modport  : the debug transport, core halt logic and register file
// Signals:
//   cmd_valid/cmd_ready/cmd_op/cmd_reg/cmd_data       command channel
//   rsp_valid/rsp_ready/rsp_reg/rsp_data/rsp_err/rsp_last  response channel
//   halt_req/halt_ack                                 core halt handshake
//   rf_wr_en/rf_wr_reg/rf_wr_data/rf_rd_reg/rf_rd_data    register file ports
interface reg_file_dbg_access_if #(
   parameter int IDX_W = 5
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [IDX_W-1:0] cmd_reg;
   logic [31:0]      cmd_data;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [IDX_W-1:0] rsp_reg;
   logic [31:0]      rsp_data;
   logic             rsp_err;
   logic             rsp_last;
   logic             halt_req;
   logic             halt_ack;
   logic             rf_wr_en;
   logic [IDX_W-1:0] rf_wr_reg;
   logic [31:0]      rf_wr_data;
   logic [IDX_W-1:0] rf_rd_reg;
   logic [31:0]      rf_rd_data;

   modport master (
      input  cmd_valid, cmd_op, cmd_reg, cmd_data, rsp_ready, halt_ack, rf_rd_data,
      output cmd_ready, rsp_valid, rsp_reg, rsp_data, rsp_err, rsp_last, halt_req,
             rf_wr_en, rf_wr_reg, rf_wr_data, rf_rd_reg
   );

   modport slave (
      output cmd_valid, cmd_op, cmd_reg, cmd_data, rsp_ready, halt_ack, rf_rd_data,
      input  cmd_ready, rsp_valid, rsp_reg, rsp_data, rsp_err, rsp_last, halt_req,
             rf_wr_en, rf_wr_reg, rf_wr_data, rf_rd_reg
   );
endinterface

// File: rtl/reg_file_dbg_access.sv
// rtl/reg_file_dbg_access.sv - debug/scan initiator for the GPR register file
//
// Purpose: takes read/write/dump commands, halts the core, drives the register
//   file ports for one cycle per access and returns one response per access.
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    reg_file_dbg_access_if.master (command, response, halt, RF ports)
// Build option: REG_DBG_DUMP_EN enables op 10 (dump of all registers);
//   without it op 10 is rejected like op 11.
module reg_file_dbg_access #(
   parameter int HALT_TIMEOUT = 16,
   parameter int NUM_REGS     = 32
) (
   input logic                   clk,
   input logic                   rst_n,
   reg_file_dbg_access_if.master bus
);
   localparam int IDX_W = $clog2(NUM_REGS);
   localparam int CNT_W = $clog2(HALT_TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_HALT, S_ACCESS, S_RESP} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [1:0]       r_op;
   logic [IDX_W-1:0] r_reg;
   logic [31:0]      r_data;
   logic [CNT_W-1:0] r_cnt;
   logic             r_halt_req;
   logic [IDX_W-1:0] r_rsp_reg;
   logic [31:0]      r_rsp_data;
   logic             r_rsp_err;
   logic             r_rsp_last;
   logic             w_op_ok;
   logic             w_timeout;
   logic             w_is_write;
   logic             w_is_dump;
   logic             w_last_idx;
   logic [IDX_W-1:0] w_acc_reg;

`ifdef REG_DBG_DUMP_EN
   logic [IDX_W-1:0] r_idx;
   assign w_op_ok    = (bus.cmd_op != 2'b11);
   assign w_is_dump  = (r_op == 2'b10);
   assign w_last_idx = (r_idx == IDX_W'(NUM_REGS - 1));
   assign w_acc_reg  = w_is_dump ? r_idx : r_reg;
`else
   assign w_op_ok    = (bus.cmd_op[1] == 1'b0);
   assign w_is_dump  = 1'b0;
   assign w_last_idx = 1'b1;
   assign w_acc_reg  = r_reg;
`endif

   assign w_is_write = (r_op == 2'b01);
   // counter holds the number of ack-less HALT cycles already completed
   assign w_timeout  = (r_cnt == CNT_W'(HALT_TIMEOUT - 1));

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (bus.cmd_valid) w_next = w_op_ok ? S_HALT : S_RESP;
         S_HALT: begin
            if (bus.halt_ack)  w_next = S_ACCESS;
            else if (w_timeout) w_next = S_RESP;
         end
         S_ACCESS: w_next = S_RESP;
         S_RESP:   if (bus.rsp_ready) w_next = r_rsp_last ? S_IDLE : S_ACCESS;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_op       <= '0;
         r_reg      <= '0;
         r_data     <= '0;
         r_cnt      <= '0;
         r_halt_req <= 1'b0;
         r_rsp_reg  <= '0;
         r_rsp_data <= '0;
         r_rsp_err  <= 1'b0;
         r_rsp_last <= 1'b0;
`ifdef REG_DBG_DUMP_EN
         r_idx      <= '0;
`endif
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: if (bus.cmd_valid) begin
               r_op   <= bus.cmd_op;
               r_reg  <= bus.cmd_reg;
               r_data <= bus.cmd_data;
               r_cnt  <= '0;
`ifdef REG_DBG_DUMP_EN
               r_idx  <= '0;
`endif
               if (w_op_ok) begin
                  r_halt_req <= 1'b1;
               end else begin
                  // rejected op: respond at once, the core is never disturbed
                  r_rsp_reg  <= bus.cmd_reg;
                  r_rsp_data <= '0;
                  r_rsp_err  <= 1'b1;
                  r_rsp_last <= 1'b1;
               end
            end
            S_HALT: if (!bus.halt_ack) begin
               r_cnt <= r_cnt + CNT_W'(1);
               if (w_timeout) begin
                  r_rsp_reg  <= r_reg;
                  r_rsp_data <= '0;
                  r_rsp_err  <= 1'b1;
                  r_rsp_last <= 1'b1;
               end
            end
            S_ACCESS: begin
               r_rsp_reg  <= w_acc_reg;
               r_rsp_data <= w_is_write ? 32'h0 : bus.rf_rd_data;
               r_rsp_err  <= 1'b0;
               r_rsp_last <= !w_is_dump || w_last_idx;
            end
            S_RESP: if (bus.rsp_ready) begin
               if (r_rsp_last) r_halt_req <= 1'b0;
`ifdef REG_DBG_DUMP_EN
               else            r_idx      <= r_idx + IDX_W'(1);
`endif
            end
            default: ;
         endcase
      end
   end

   assign bus.cmd_ready  = rst_n && (r_state == S_IDLE);
   assign bus.rsp_valid  = (r_state == S_RESP);
   assign bus.rsp_reg    = r_rsp_reg;
   assign bus.rsp_data   = r_rsp_data;
   assign bus.rsp_err    = r_rsp_err;
   assign bus.rsp_last   = r_rsp_last;
   assign bus.halt_req   = r_halt_req;
   // x0 is hard-wired zero, so a write to it is silently dropped
   assign bus.rf_wr_en   = (r_state == S_ACCESS) && w_is_write && (r_reg != '0);
   assign bus.rf_wr_reg  = r_reg;
   assign bus.rf_wr_data = r_data;
   assign bus.rf_rd_reg  = w_acc_reg;
endmodule

// File: tb/tb_reg_file_dbg_access.sv
// tb/tb_reg_file_dbg_access.sv - randomized self-checking bench for reg_file_dbg_access
module tb_reg_file_dbg_access;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   reg_file_dbg_access_if bus();

   reg_file_dbg_access dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // register file: write on rising edge, combinational read, x0 reads 0
   logic [31:0] rf_mem [0:31];
   always @(posedge clk) begin
      if (bus.rf_wr_en && bus.rf_wr_reg != 5'd0) rf_mem[bus.rf_wr_reg] <= bus.rf_wr_data;
   end
   assign bus.rf_rd_data = (bus.rf_rd_reg == 5'd0) ? 32'h0 : rf_mem[bus.rf_rd_reg];

`ifdef REG_DBG_DUMP_EN
   localparam bit DUMP_ON = 1'b1;
`else
   localparam bit DUMP_ON = 1'b0;
`endif

   typedef struct packed {
      logic [4:0]  r;
      logic [31:0] d;
      logic        e;
      logic        l;
   } rsp_t;

   logic [31:0] ref_mem [0:31];
   int n_total = 0;
   int n_bad   = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   function automatic rsp_t mk(input logic [4:0] r, input logic [31:0] d, input logic e, input logic l);
      rsp_t x;
      x.r = r; x.d = d; x.e = e; x.l = l;
      return x;
   endfunction

   function automatic logic [31:0] rdval(input logic [4:0] r);
      return (r == 5'd0) ? 32'h0 : ref_mem[r];
   endfunction

   // ack_dly: 0 = halt_ack never rises, k>=1 = halt_ack seen at the k-th edge after handshake
   task automatic do_cmd(input logic [1:0] op, input logic [4:0] r, input logic [31:0] d,
                         input int ack_dly, input int hold_min, input int hold_max);
      rsp_t q[$];
      int   lat, cyc, wr_cnt, hold, exp_wr;
      bit   err_op, first, done, halt_seen;
      err_op = (op == 2'b11) || (op == 2'b10 && !DUMP_ON);
      exp_wr = 0;
      if (err_op) begin
         q.push_back(mk(r, 32'h0, 1'b1, 1'b1));
         lat = 1;
      end else if (ack_dly == 0) begin
         q.push_back(mk(r, 32'h0, 1'b1, 1'b1));
         lat = 17;
      end else begin
         lat = ack_dly + 2;
         case (op)
            2'b00: q.push_back(mk(r, rdval(r), 1'b0, 1'b1));
            2'b01: begin
               q.push_back(mk(r, 32'h0, 1'b0, 1'b1));
               exp_wr = (r != 5'd0) ? 1 : 0;
            end
            default: for (int i = 0; i < 32; i++) q.push_back(mk(5'(i), rdval(5'(i)), 1'b0, i == 31));
         endcase
      end

      @(negedge clk);
      check("idle_cmd_ready", bus.cmd_ready, 1'b1);
      bus.halt_ack  = (ack_dly == 1);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_reg   = r;
      bus.cmd_data  = d;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      cyc = 1; wr_cnt = 0; first = 1'b1; done = 1'b0; halt_seen = 1'b0;
      hold = $urandom_range(hold_min, hold_max);
      while (!done && cyc < 400) begin
         bus.rsp_ready = 1'b0;
         if (ack_dly > 1 && cyc >= ack_dly) bus.halt_ack = 1'b1;
         if (!first && $urandom_range(0, 1) == 1) bus.halt_ack = 1'b0;
         if (bus.halt_req) halt_seen = 1'b1;
         if (bus.rf_wr_en) begin
            wr_cnt++;
            check("wr_port", {bus.rf_wr_reg, bus.rf_wr_data}, {r, d});
         end
         if (bus.rsp_valid) begin
            if (first) begin
               check("latency", cyc, lat);
               first = 1'b0;
            end
            if (q.size() == 0) begin
               check("extra_rsp", 1'b1, 1'b0);
               done = 1'b1;
            end else begin
               check("rsp", {bus.rsp_reg, bus.rsp_data, bus.rsp_err, bus.rsp_last}, q[0]);
               check("halt_in_rsp", bus.halt_req, !err_op);
               check("busy_cmd_ready", bus.cmd_ready, 1'b0);
               if (hold > 0) hold--;
               else begin
                  bus.rsp_ready = 1'b1;
                  if (q[0].l) done = 1'b1;
                  void'(q.pop_front());
                  hold = $urandom_range(hold_min, hold_max);
               end
            end
         end
         @(negedge clk);
         cyc++;
      end
      bus.rsp_ready = 1'b0;
      bus.halt_ack  = 1'b0;
      check("cmd_finished", done, 1'b1);
      check("rsp_left", q.size(), 0);
      check("post_cmd_ready", bus.cmd_ready, 1'b1);
      check("post_halt_req", bus.halt_req, 1'b0);
      check("post_rsp_valid", bus.rsp_valid, 1'b0);
      check("wr_pulses", wr_cnt, exp_wr);
      if (err_op) check("no_halt", halt_seen, 1'b0);
      if (exp_wr == 1) ref_mem[r] = d;
   endtask

   // start a command, run until stop point, then pulse reset for one cycle
   task automatic reset_mid(input logic [1:0] op, input logic [4:0] r, input bit ack, input int stop_reg);
      bit reached, quiet;
      @(negedge clk);
      bus.halt_ack  = ack;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_reg   = r;
      bus.cmd_data  = 32'h0;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      reached = 1'b0;
      for (int c = 0; c < 300; c++) begin
         if ((stop_reg < 0 && c == 5) ||
             (stop_reg >= 0 && bus.rsp_valid && int'(bus.rsp_reg) == stop_reg)) begin
            reached = 1'b1;
            break;
         end
         bus.rsp_ready = bus.rsp_valid;
         @(negedge clk);
         bus.rsp_ready = 1'b0;
      end
      bus.rsp_ready = 1'b0;
      check("rst_stop_reached", reached, 1'b1);
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_mid_outputs", {bus.rsp_valid, bus.halt_req, bus.cmd_ready, bus.rf_wr_en}, 4'b0000);
      rst_n = 1'b1;
      bus.halt_ack = 1'b0;
      quiet = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (bus.rsp_valid || bus.halt_req) quiet = 1'b0;
      end
      check("rst_quiet", quiet, 1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [1:0]  op;
      logic [4:0]  r;
      logic [31:0] d;
      int          sel, ack;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'b00;
      bus.cmd_reg   = 5'd0;
      bus.cmd_data  = 32'h0;
      bus.rsp_ready = 1'b0;
      bus.halt_ack  = 1'b0;
      for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ctrl", {bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_last, bus.halt_req, bus.rf_wr_en}, 6'b0);
      check("rst_rsp_fields", {bus.rsp_reg, bus.rsp_data}, 37'h0);
      check("rst_rf_fields", {bus.rf_wr_reg, bus.rf_wr_data, bus.rf_rd_reg}, 42'h0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_ready", bus.cmd_ready, 1'b1);

      for (int i = 1; i < 32; i++) do_cmd(2'b01, 5'(i), 32'(i) * 32'h1111_1111, 1, 0, 0);

      do_cmd(2'b01, 5'd5, 32'hDEAD_BEEF, 1, 0, 0);
      do_cmd(2'b00, 5'd5, 32'h0, 1, 0, 0);
      do_cmd(2'b01, 5'd0, 32'hFFFF_FFFF, 1, 0, 0);
      do_cmd(2'b00, 5'd0, 32'h0, 1, 0, 0);
      do_cmd(2'b00, 5'd3, 32'h0, 0, 0, 0);
      do_cmd(2'b01, 5'd7, 32'h1234_5678, 1, 0, 0);
      do_cmd(2'b00, 5'd7, 32'h0, 1, 5, 5);
      do_cmd(2'b01, 5'd5, 32'h5555_5555, 4, 0, 0);
      do_cmd(2'b01, 5'd7, 32'h7777_7777, 1, 0, 0);
      do_cmd(2'b10, 5'd0, 32'h0, 1, 0, 1);
      do_cmd(2'b11, 5'd9, 32'h0, 1, 0, 0);

      reset_mid(2'b00, 5'd3, 1'b0, -1);
`ifdef REG_DBG_DUMP_EN
      reset_mid(2'b10, 5'd0, 1'b1, 10);
`endif
      do_cmd(2'b00, 5'd12, 32'h0, 1, 0, 0);

      for (int k = 0; k < 80; k++) begin
         op  = 2'($urandom_range(0, 3));
         r   = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 7) == 0) r = 5'd0;
         d   = $urandom;
         sel = $urandom_range(0, 9);
         ack = (sel == 0) ? 0 : (sel < 6) ? 1 : $urandom_range(2, 12);
         do_cmd(op, r, d, ack, 0, 3);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
